// File: rtl/sr04_ranger.sv
// HC-SR04 ultrasonic ranger: periodic trigger, echo pulse timing with timeout,
// and an 8-step thermometer bar derived from the measured echo width.
module sr04_ranger #(
    parameter int unsigned TRIG_CYCLES    = 25,
    parameter int unsigned PERIOD_CYCLES  = 124800,
    parameter int unsigned TIMEOUT_CYCLES = 62400,
    parameter int unsigned BAR_STEP       = 1206
) (
    input  logic        osc_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic        meas_valid,
    output logic [15:0] meas_cycles,
    output logic        meas_timeout,
    output logic [7:0]  led_bar
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_t;

    localparam logic [16:0] PER_LAST  = 17'(PERIOD_CYCLES - 1);
    localparam logic [15:0] TRIG_LAST = 16'(TRIG_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] TO_FULL   = 16'(TIMEOUT_CYCLES);

    state_t      state_reg, state_next;
    logic [15:0] ph_cnt_reg, ph_cnt_next;
    logic [16:0] per_cnt_reg;
    logic        echo_meta_reg, echo_s_reg;
    logic        echo_s;
    logic        trig_reg;
    logic        meas_valid_reg;
    logic [15:0] meas_cycles_reg;
    logic        meas_timeout_reg;
    logic [7:0]  led_bar_reg;

    logic        post_valid;
    logic        post_timeout;
    logic [15:0] post_cycles;
    logic [7:0]  bar_next;

    assign echo_s = echo_s_reg;

    // Thermometer level from constant thresholds; bit gi lights at (gi+1)*BAR_STEP.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bar
            localparam logic [31:0] THRESH = 32'((gi + 1) * BAR_STEP);
            assign bar_next[gi] = (32'(post_cycles) >= THRESH);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        ph_cnt_next  = ph_cnt_reg;
        post_valid   = 1'b0;
        post_timeout = 1'b0;
        post_cycles  = ph_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next  = ST_TRIG;
                    ph_cnt_next = '0;
                end
            end
            ST_TRIG: begin
                if (ph_cnt_reg == TRIG_LAST) begin
                    state_next  = ST_WAIT_RISE;
                    ph_cnt_next = '0;
                end else begin
                    ph_cnt_next = ph_cnt_reg + 16'd1;
                end
            end
            ST_WAIT_RISE: begin
                // The cycle that first sees echo_s high is itself the first counted cycle.
                if (echo_s) begin
                    state_next  = ST_MEASURE;
                    ph_cnt_next = 16'd1;
                end else if (ph_cnt_reg == TO_LAST) begin
                    state_next   = ST_HOLDOFF;
                    post_valid   = 1'b1;
                    post_timeout = 1'b1;
                end else begin
                    ph_cnt_next = ph_cnt_reg + 16'd1;
                end
            end
            ST_MEASURE: begin
                if (!echo_s) begin
                    state_next = ST_HOLDOFF;
                    post_valid = 1'b1;
                end else if (ph_cnt_reg == TO_FULL) begin
                    state_next   = ST_HOLDOFF;
                    post_valid   = 1'b1;
                    post_timeout = 1'b1;
                end else begin
                    ph_cnt_next = ph_cnt_reg + 16'd1;
                end
            end
            ST_HOLDOFF: begin
                if (per_cnt_reg == PER_LAST && !echo_s) begin
                    state_next  = enable ? ST_TRIG : ST_IDLE;
                    ph_cnt_next = '0;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                ph_cnt_next = '0;
            end
        endcase

        if (post_timeout) begin
            post_cycles = 16'hFFFF;
        end
    end

    always_ff @(posedge osc_clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            ph_cnt_reg       <= '0;
            per_cnt_reg      <= '0;
            echo_meta_reg    <= 1'b0;
            echo_s_reg       <= 1'b0;
            trig_reg         <= 1'b0;
            meas_valid_reg   <= 1'b0;
            meas_cycles_reg  <= '0;
            meas_timeout_reg <= 1'b0;
            led_bar_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            ph_cnt_reg    <= ph_cnt_next;
            echo_meta_reg <= echo;
            echo_s_reg    <= echo_meta_reg;
            trig_reg      <= (state_next == ST_TRIG);

            // Period reference restarts on the cycle trig rises.
            if (state_next == ST_TRIG && state_reg != ST_TRIG) begin
                per_cnt_reg <= '0;
            end else if (per_cnt_reg != PER_LAST) begin
                per_cnt_reg <= per_cnt_reg + 17'd1;
            end

            meas_valid_reg <= post_valid;
            if (post_valid) begin
                meas_cycles_reg  <= post_cycles;
                meas_timeout_reg <= post_timeout;
                led_bar_reg      <= post_timeout ? 8'h00 : bar_next;
            end
        end
    end

    assign trig         = trig_reg;
    assign meas_valid   = meas_valid_reg;
    assign meas_cycles  = meas_cycles_reg;
    assign meas_timeout = meas_timeout_reg;
    assign led_bar      = led_bar_reg;

endmodule

// File: tb/tb_sr04_ranger.sv
// Scoreboard bench for sr04_ranger with scaled-down timing parameters;
// expected posts are queued when echo stimulus is driven and popped on meas_valid.
module tb_sr04_ranger;

    localparam int TRIG = 5;
    localparam int PER  = 2000;
    localparam int TO   = 800;
    localparam int STEP = 50;

    typedef struct {
        logic [15:0] cycles;
        logic        to;
        logic [7:0]  led;
        int          at;
    } exp_t;

    logic        osc_clk;
    logic        rst;
    logic        enable;
    logic        echo;
    logic        trig;
    logic        meas_valid;
    logic [15:0] meas_cycles;
    logic        meas_timeout;
    logic [7:0]  led_bar;

    int   cyc = 0;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    int   r_prev = 0;
    exp_t sb[$];

    sr04_ranger #(
        .TRIG_CYCLES   (TRIG),
        .PERIOD_CYCLES (PER),
        .TIMEOUT_CYCLES(TO),
        .BAR_STEP      (STEP)
    ) dut (
        .osc_clk     (osc_clk),
        .rst         (rst),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .meas_valid  (meas_valid),
        .meas_cycles (meas_cycles),
        .meas_timeout(meas_timeout),
        .led_bar     (led_bar)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    always @(posedge osc_clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: trig width and scoreboard comparison on each post.
    logic prev_trig = 1'b0;
    int   rise_cyc  = 0;
    always @(negedge osc_clk) begin
        exp_t e;
        if (trig && !prev_trig) rise_cyc = cyc;
        if (!trig && prev_trig && !rst) check_value("trig_width", cyc - rise_cyc, TRIG);
        prev_trig = trig;
        if (meas_valid) begin
            if (sb.size() == 0) begin
                check_value("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check_value("meas_cycles", meas_cycles, e.cycles);
                check_value("meas_timeout", meas_timeout, e.to);
                check_value("led_bar", led_bar, e.led);
                check_value("post_time", cyc, e.at);
                $display("post cycles=%0d timeout=%0b led=%02h at=%0d", meas_cycles, meas_timeout, led_bar, cyc);
            end
        end
    end

    task automatic tick();
        @(negedge osc_clk);
    endtask

    task automatic wait_trig(input logic level, input int budget, output int at);
        int n = 0;
        while (trig !== level && n < budget) begin
            tick();
            n++;
        end
        if (trig !== level) check_value("trig_wait", trig, level);
        at = cyc;
    endtask

    task automatic push_exp(input logic [15:0] c, input logic t, input logic [7:0] l, input int at);
        exp_t e;
        e.cycles = c;
        e.to     = t;
        e.led    = l;
        e.at     = at;
        sb.push_back(e);
    endtask

    task automatic next_rise();
        int r;
        wait_trig(1'b1, 2 * PER, r);
        check_value("trig_period", r - r_prev, PER);
        check_value("sb_drained", sb.size(), 0);
        r_prev = r;
    endtask

    task automatic run_no_echo();
        int f;
        wait_trig(1'b0, 4 * TRIG, f);
        push_exp(16'hFFFF, 1'b1, 8'h00, f + TO);
        next_rise();
    endtask

    task automatic run_echo(input int delay, input int hold, input logic [7:0] led_exp);
        int f;
        int d;
        wait_trig(1'b0, 4 * TRIG, f);
        repeat (delay) tick();
        d = cyc;
        push_exp(16'(hold), 1'b0, led_exp, d + hold + 3);
        echo = 1'b1;
        repeat (hold) tick();
        echo = 1'b0;
        next_rise();
    endtask

    task automatic run_stuck();
        int f;
        int d;
        int l;
        int r;
        wait_trig(1'b0, 4 * TRIG, f);
        repeat (20) tick();
        d = cyc;
        push_exp(16'hFFFF, 1'b1, 8'h00, d + TO + 3);
        echo = 1'b1;
        while (cyc < r_prev + PER + 50) tick();
        check_value("stuck_holdoff_trig", trig, 0);
        check_value("stuck_sb_drained", sb.size(), 0);
        echo = 1'b0;
        l = cyc;
        wait_trig(1'b1, 100, r);
        check_value("stuck_release", r - l, 3);
        r_prev = r;
    endtask

    task automatic run_reset();
        int f;
        wait_trig(1'b0, 4 * TRIG, f);
        repeat (30) tick();
        echo = 1'b1;
        repeat (50) tick();
        rst = 1'b1;
        #1;
        check_value("rst_trig", trig, 0);
        check_value("rst_valid", meas_valid, 0);
        check_value("rst_cycles", meas_cycles, 0);
        check_value("rst_timeout", meas_timeout, 0);
        check_value("rst_led", led_bar, 0);
        repeat (3) tick();
        echo = 1'b0;
        rst = 1'b0;
        tick();
        check_value("rst_restart_trig", trig, 1);
        r_prev = cyc;
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        echo   = 1'b0;
        repeat (3) tick();
        check_value("reset_trig", trig, 0);
        check_value("reset_valid", meas_valid, 0);
        check_value("reset_cycles", meas_cycles, 0);
        check_value("reset_timeout", meas_timeout, 0);
        check_value("reset_led", led_bar, 0);
        rst = 1'b0;
        repeat (5) tick();
        check_value("idle_trig", trig, 0);

        enable = 1'b1;
        tick();
        check_value("start_trig", trig, 1);
        r_prev = cyc;

        run_no_echo();
        run_echo(100, STEP, 8'h01);
        run_echo(100, 500, 8'hFF);
        run_echo(100, STEP - 1, 8'h00);
        run_echo(60, 175, 8'h07);
        run_stuck();
        run_reset();
        run_no_echo();

        check_value("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
